// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

  // Controller states: wait for a request, iterate, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit value replicated across the product register on reset.
  localparam logic P_RESET_BIT = 1'b0;

endpackage

// File: rtl/scalable_adder.sv
// Unsigned adder: DATA_WIDTH-bit operands, DATA_WIDTH+1-bit sum (carry kept).
module scalable_adder #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH:0]   S
);

  // Zero-extend both operands so the carry lands in the top bit.
  always_comb begin
    S = {1'b0, A} + {1'b0, B};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one partial-product add and right shift per
// clock, DATA_WIDTH iterations, start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 in IDLE
// captures A and B. busy is high for the DATA_WIDTH iteration cycles; done is a
// one-cycle pulse in which P already holds the new product. P keeps its value
// until the next completion. start seen in RUN or DONE is dropped.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] P
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   mcand;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   addend;
  logic [N:0]     sum;
  logic           last_iter;

  // Add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    addend = acc_lo[0] ? mcand : '0;
  end

  scalable_adder #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .A (acc_hi),
    .B (addend),
    .S (sum)
  );

  assign last_iter = (cnt == LAST_CNT);

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, operand capture, shift-accumulate datapath and product load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      P      <= {(2*N){P_RESET_BIT}};
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= A;
            acc_lo <= B;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          // The adder carry becomes the new MSB of acc_hi, so nothing is lost.
          acc_hi <= sum[N:1];
          acc_lo <= {sum[0], acc_lo[N-1:1]};
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            P <= {sum, acc_lo[N-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: a 4-bit and an 8-bit instance sharing one
// clock and reset. Expected products come from plain A*B.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst_n;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [7:0] p4;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;

  shift_add_multiplier #(.DATA_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .P(p4)
  );

  shift_add_multiplier #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         prod;
  } vec_t;
  vec_t vecs[8];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned product.
  function automatic logic [15:0] model(input int w, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    if (w == 4) r = 16'({12'd0, a[3:0]} * {12'd0, b[3:0]});
    else        r = {8'd0, a} * {8'd0, b};
    return r;
  endfunction

  function automatic int cur_busy(input int w);
    return (w == 4) ? int'(busy4) : int'(busy8);
  endfunction
  function automatic int cur_done(input int w);
    return (w == 4) ? int'(done4) : int'(done8);
  endfunction
  function automatic int cur_p(input int w);
    return (w == 4) ? int'(p4) : int'(p8);
  endfunction

  // ---------------- driver ----------------
  task automatic drive_start(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = s; a8 = a; b8 = b;
    end
  endtask

  // One full transaction: accept, check busy length, done timing, pulse width and product.
  task automatic do_mult(input int w, input logic [7:0] a, input logic [7:0] b, output int got);
    int busy_cnt;
    int done_at;
    int overlap;
    logic [15:0] exp_p;
    got = -1;
    @(negedge clk);
    drive_start(w, 1'b1, a, b);
    exp_q.push_back(model(w, a, b));
    @(negedge clk);
    drive_start(w, 1'b0, 8'($urandom), 8'($urandom));
    busy_cnt = 0;
    done_at  = -1;
    overlap  = 0;
    for (int i = 1; i <= w + 8 && done_at < 0; i++) begin
      if (cur_busy(w) != 0 && cur_done(w) != 0) overlap = 1;
      if (cur_busy(w) != 0) busy_cnt++;
      if (cur_done(w) != 0) begin
        done_at = i;
        got = cur_p(w);
      end
      if (done_at < 0) @(negedge clk);
    end
    check("done_latency", done_at, w + 1);
    check("busy_cycles", busy_cnt, w);
    check("busy_done_overlap", overlap, 0);
    if (exp_q.size() > 0) begin
      exp_p = exp_q.pop_front();
      check("product", got, int'(exp_p));
    end
    @(negedge clk);
    check("done_width", cur_done(w), 0);
    check("idle_after_done", cur_busy(w), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int got;
    int last_done;
    int n_done;
    int gap_bad;
    int p_bad;
    logic [7:0] ra, rb;

    vecs[0] = '{4'd13, 4'd11, 143};
    vecs[1] = '{4'd15, 4'd15, 225};
    vecs[2] = '{4'd0,  4'd9,  0};
    vecs[3] = '{4'd7,  4'd0,  0};
    vecs[4] = '{4'd6,  4'd5,  30};
    vecs[5] = '{4'd1,  4'd1,  1};
    vecs[6] = '{4'd15, 4'd1,  15};
    vecs[7] = '{4'd8,  4'd15, 120};

    rst_n = 1'b0;
    drive_start(4, 1'b0, 8'd0, 8'd0);
    drive_start(8, 1'b0, 8'd0, 8'd0);
    #12;
    check("reset_busy", int'(busy4), 0);
    check("reset_done", int'(done4), 0);
    check("reset_p", int'(p4), 0);
    check("reset_p8", int'(p8), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors on the 4-bit instance.
    for (int i = 0; i < 8; i++) begin
      do_mult(4, {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, got);
      check("table_product", got, vecs[i].prod);
    end

    // Start held high: one accept every N+2 cycles, P stable between completions.
    @(negedge clk);
    drive_start(4, 1'b1, 8'd9, 8'd7);
    last_done = -1;
    n_done = 0;
    gap_bad = 0;
    p_bad = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done4) begin
        if (last_done >= 0 && j - last_done != 6) gap_bad++;
        last_done = j;
        n_done++;
      end
      if (j >= 5 && p4 != 8'd63) p_bad++;
      if (j < 5 && p4 != 8'd120) p_bad++;
    end
    check("held_start_done_count", n_done, 6);
    check("held_start_gap", gap_bad, 0);
    check("held_start_p_stable", p_bad, 0);
    drive_start(4, 1'b0, 8'd0, 8'd0);
    repeat (10) @(negedge clk);

    // start pulsed mid-RUN is ignored.
    drive_start(4, 1'b1, 8'd6, 8'd5);
    @(negedge clk);
    drive_start(4, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    drive_start(4, 1'b1, 8'd1, 8'd1);
    @(negedge clk);
    drive_start(4, 1'b0, 8'd0, 8'd0);
    n_done = 0;
    for (int j = 0; j < 16; j++) begin
      if (done4) n_done++;
      @(negedge clk);
    end
    check("ignored_start_done_count", n_done, 1);
    check("ignored_start_product", int'(p4), 30);

    // Asynchronous reset after two iterations aborts the operation.
    drive_start(4, 1'b1, 8'd13, 8'd11);
    @(negedge clk);
    drive_start(4, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy4), 0);
    check("abort_done", int'(done4), 0);
    check("abort_p", int'(p4), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done4 || busy4) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_p_held", int'(p4), 0);
    do_mult(4, 8'd3, 8'd4, got);

    // Wide instance corner case plus random sweeps on both widths.
    do_mult(8, 8'd255, 8'd255, got);
    check("max_product_8", got, 65025);
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_mult(8, ra, rb, got);
    end
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      do_mult(4, ra, rb, got);
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
